// File: rtl/mmio_responder_if.sv
// Processor memory-port bundle: ADDR/DOUT/W toward the responder, DIN back.
interface mmio_responder_if;
    logic [7:0]  address;
    logic [15:0] data;
    logic        wren;
    logic [15:0] q;

    modport master (output address, output data, output wren, input q);
    modport slave  (input address, input data, input wren, output q);
endinterface

// File: rtl/mmio_responder.sv
// Memory-mapped responder for the processor data port: data RAM, LED register,
// synchronized switches and a prescaled 16-bit down-counting timer.
// Optional seven-segment HEX register at 0xB0 is built only when the macro
// MMIO_HEX_DISPLAY_EN is defined; otherwise the HEX outputs are blank.
module mmio_responder #(
    parameter int PRESCALE  = 50000,
    parameter int RAM_WORDS = 128
) (
    input  logic             clk_50MHz,
    input  logic             reset_n,
    mmio_responder_if.slave  bus,
    input  logic [9:0]       SW,
    output logic [15:0]      LEDR,
    output logic             tmr_expired,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);
    localparam int             PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [8:0]     RAM_LIMIT = 9'(RAM_WORDS);

    logic [15:0]   r_ram [RAM_WORDS];
    logic [15:0]   r_q;
    logic [15:0]   r_led;
    logic [9:0]    r_sw_s1;
    logic [9:0]    r_sw_s2;
    logic          r_en;
    logic          r_reload;
    logic [15:0]   r_load;
    logic [15:0]   r_count;
    logic          r_expired;
    logic [PW-1:0] r_presc;

    logic          w_ram_sel;
    logic          w_wr_ram;
    logic          w_wr_led;
    logic          w_wr_ctrl;
    logic          w_wr_load;
    logic          w_wr_status;
    logic          w_tick;
    logic          w_set_exp;
    logic          w_clr_exp;
    logic [15:0]   w_rdata;

    assign w_ram_sel   = ({1'b0, bus.address} < RAM_LIMIT);
    assign w_wr_ram    = bus.wren && w_ram_sel;
    assign w_wr_led    = bus.wren && (bus.address == 8'h80);
    assign w_wr_ctrl   = bus.wren && (bus.address == 8'hA0);
    assign w_wr_load   = bus.wren && (bus.address == 8'hA1);
    assign w_wr_status = bus.wren && (bus.address == 8'hA3);

    // A tick fires on the cycle the prescaler wraps back to zero.
    assign w_tick    = r_en && (r_presc == PRESC_MAX);
    // A LOAD write overrides any coincident tick, so it also suppresses expiry.
    assign w_set_exp = w_tick && !w_wr_load && (r_count == 16'd1);
    assign w_clr_exp = w_wr_status && bus.data[0];

    assign bus.q       = r_q;
    assign LEDR        = r_led;
    assign tmr_expired = r_expired;

`ifdef MMIO_HEX_DISPLAY_EN
    logic [15:0] r_hex;
    logic        w_wr_hex;

    assign w_wr_hex = bus.wren && (bus.address == 8'hB0);

    // Hex nibble to active-low segments, bit order gfedcba.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // HEX display register, written like any other R/W register.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_hex <= '0;
        end else if (w_wr_hex) begin
            r_hex <= bus.data;
        end
    end

    assign HEX0 = seg7(r_hex[3:0]);
    assign HEX1 = seg7(r_hex[7:4]);
    assign HEX2 = seg7(r_hex[11:8]);
    assign HEX3 = seg7(r_hex[15:12]);
`else
    assign HEX0 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX3 = 7'h7F;
`endif

    // Read mux: selects the addressed word from current (pre-edge) state.
    always_comb begin
        w_rdata = '0;
        if (w_ram_sel) begin
            w_rdata = r_ram[bus.address[6:0]];
        end else begin
            case (bus.address)
                8'h80:   w_rdata = r_led;
                8'h90:   w_rdata = {6'b0, r_sw_s2};
                8'hA0:   w_rdata = {14'b0, r_reload, r_en};
                8'hA1:   w_rdata = r_load;
                8'hA2:   w_rdata = r_count;
                8'hA3:   w_rdata = {15'b0, r_expired};
`ifdef MMIO_HEX_DISPLAY_EN
                8'hB0:   w_rdata = r_hex;
`endif
                default: w_rdata = '0;
            endcase
        end
    end

    // Data RAM: no reset, write-first is avoided so reads see the old word.
    always_ff @(posedge clk_50MHz) begin
        if (w_wr_ram) begin
            r_ram[bus.address[6:0]] <= bus.data;
        end
    end

    // Registered read data, LED register and two-flop switch synchronizer.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_q     <= '0;
            r_led   <= '0;
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_q     <= w_rdata;
            r_sw_s1 <= SW;
            r_sw_s2 <= r_sw_s1;
            if (w_wr_led) begin
                r_led <= bus.data;
            end
        end
    end

    // Timer control, prescaler, down-counter and sticky expired flag.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_en      <= 1'b0;
            r_reload  <= 1'b0;
            r_load    <= '0;
            r_count   <= '0;
            r_expired <= 1'b0;
            r_presc   <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en     <= bus.data[0];
                r_reload <= bus.data[1];
            end
            if (w_wr_load) begin
                r_load  <= bus.data;
                r_count <= bus.data;
                r_presc <= '0;
            end else begin
                if (!r_en || w_tick) begin
                    r_presc <= '0;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
                if (w_tick) begin
                    if (r_count > 16'd1) begin
                        r_count <= r_count - 16'd1;
                    end else if (r_count == 16'd1) begin
                        r_count <= 16'd0;
                    end else if (r_reload) begin
                        r_count <= r_load;
                    end
                end
            end
            // Set has priority over a coincident write-1-to-clear.
            if (w_set_exp) begin
                r_expired <= 1'b1;
            end else if (w_clr_exp) begin
                r_expired <= 1'b0;
            end
        end
    end
endmodule
